// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_if
// Description : Bundles the parallel-word handshake and the serial output
//               stream of the PISO serializer.
//                 data_in    [WIDTH] parallel word offered by the producer
//                 data_valid         data_in holds a word
//                 data_ready         serializer can take a word
//                 ser_out            serial bit
//                 ser_valid          ser_out carries a live bit
//                 ser_first          ser_out is the first bit of a word
//                 ser_last           ser_out is the last bit of a word
//                 busy               serializer is shifting a word
//               master : producer / consumer side (testbench, upstream)
//               slave  : the serializer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_first,
    input  ser_last,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output ser_out,
    output ser_valid,
    output ser_first,
    output ser_last,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out stage. Accepts WIDTH-bit words over
//               a valid/ready handshake and shifts each word out one bit per
//               clock. A one-word holding buffer allows the next word to be
//               accepted while the current one is still shifting, so
//               back-to-back words stream without an idle cycle.
// Ports       : clk    in   clock, rising edge
//               rst_n  in   asynchronous reset, active-low
//               bus    slave modport of piso_serializer_if
//                      (data_in/data_valid in; data_ready, ser_out,
//                       ser_valid, ser_first, ser_last, busy out)
// Parameters  : WIDTH      word width (>= 2)
//               MSB_FIRST  1: bit WIDTH-1 first, 0: bit 0 first
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  piso_serializer_if.slave bus
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   r_hold;
  logic               r_hold_full;
  logic               r_ser_out;
  logic               r_ser_valid;
  logic               r_ser_first;
  logic               r_ser_last;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]   w_hold_nxt;
  logic               w_hold_full_nxt;
  logic               w_ser_out_nxt;
  logic               w_ser_valid_nxt;
  logic               w_ser_first_nxt;
  logic               w_ser_last_nxt;

  logic               w_xfer;
  logic [WIDTH-1:0]   w_shift_adv;
  logic               w_head_nxt;

  // data_ready depends only on a register, so there is no combinational
  // path from data_valid back to data_ready.
  assign w_xfer = bus.data_valid & ~r_hold_full;

  // Bit order: the outgoing bit is always the "head" end of the shift
  // register; advancing moves the next bit into the head position.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
      assign w_head_nxt  = w_shift_nxt[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
      assign w_head_nxt  = w_shift_nxt[0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_ser_first <= w_ser_first_nxt;
      r_ser_last  <= w_ser_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_bit_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = bus.data_in;
          w_cnt_nxt   = '0;
        end
      end

      S_SHIFT: begin
        if (r_bit_cnt == c_LAST) begin
          // Edge that retires the last bit: reload without a gap if a word
          // is available, held word taking priority over the input port.
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_cnt_nxt       = '0;
            w_hold_full_nxt = w_xfer;
            if (w_xfer) begin
              w_hold_nxt = bus.data_in;
            end
          end else if (w_xfer) begin
            w_shift_nxt = bus.data_in;
            w_cnt_nxt   = '0;
          end else begin
            // Clearing the shift register keeps ser_out low while idle.
            w_state_nxt = S_IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_shift_nxt = w_shift_adv;
          w_cnt_nxt   = r_bit_cnt + c_CNT_W'(1);
          if (w_xfer) begin
            w_hold_nxt      = bus.data_in;
            w_hold_full_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_shift_nxt     = '0;
        w_cnt_nxt       = '0;
        w_hold_full_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode, registered so every serial output is glitch-free
  // --------------------------------------------------------------------------
  always_comb begin
    w_ser_valid_nxt = (w_state_nxt == S_SHIFT);
    w_ser_out_nxt   = w_ser_valid_nxt & w_head_nxt;
    w_ser_first_nxt = w_ser_valid_nxt & (w_cnt_nxt == '0);
    w_ser_last_nxt  = w_ser_valid_nxt & (w_cnt_nxt == c_LAST);
  end

  assign bus.data_ready = ~r_hold_full;
  assign bus.ser_out    = r_ser_out;
  assign bus.ser_valid  = r_ser_valid;
  assign bus.ser_first  = r_ser_first;
  assign bus.ser_last   = r_ser_last;
  assign bus.busy       = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed testbench for piso_serializer. Two instances share
//               clk/rst_n: dut_m sends MSB first, dut_l sends LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  piso_serializer_if #(.WIDTH(4)) ifm ();
  piso_serializer_if #(.WIDTH(4)) ifl ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifm.slave)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifl.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both instances must be in their quiescent state.
  task automatic chk_idle(input string tag);
    chk({tag, "_m_valid"}, 32'(ifm.ser_valid),  32'd0);
    chk({tag, "_m_out"},   32'(ifm.ser_out),    32'd0);
    chk({tag, "_m_first"}, 32'(ifm.ser_first),  32'd0);
    chk({tag, "_m_last"},  32'(ifm.ser_last),   32'd0);
    chk({tag, "_m_busy"},  32'(ifm.busy),       32'd0);
    chk({tag, "_m_ready"}, 32'(ifm.data_ready), 32'd1);
    chk({tag, "_l_valid"}, 32'(ifl.ser_valid),  32'd0);
    chk({tag, "_l_out"},   32'(ifl.ser_out),    32'd0);
    chk({tag, "_l_busy"},  32'(ifl.busy),       32'd0);
    chk({tag, "_l_ready"}, 32'(ifl.data_ready), 32'd1);
  endtask

  // Bit k of a stream on dut_m: position within the 4-bit word sets first/last.
  task automatic chk_bit_m(input string tag, input int k, input logic b);
    chk({tag, "_valid"}, 32'(ifm.ser_valid), 32'd1);
    chk({tag, "_busy"},  32'(ifm.busy),      32'd1);
    chk({tag, "_out"},   32'(ifm.ser_out),   32'(b));
    chk({tag, "_first"}, 32'(ifm.ser_first), 32'((k % 4) == 0));
    chk({tag, "_last"},  32'(ifm.ser_last),  32'((k % 4) == 3));
  endtask

  initial begin
    logic [3:0]  bits4;
    logic [3:0]  lbits4;
    logic [3:0]  sipo;
    logic [7:0]  s8;
    logic [11:0] s12;

    rst_n          = 1'b1;
    ifm.data_in    = '0;
    ifm.data_valid = 1'b0;
    ifl.data_in    = '0;
    ifl.data_valid = 1'b0;

    // Asynchronous reset: checked before the first clock edge.
    #3 rst_n = 1'b0;
    #1 chk_idle("reset_async");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    chk_idle("reset_release");

    // No valid for 20 cycles: nothing starts.
    for (int i = 0; i < 20; i++) begin
      tick;
      chk_idle("idle20");
    end

    // Single word 1000, MSB first, captured by a SIPO model.
    ifm.data_in    = 4'b1000;
    ifm.data_valid = 1'b1;
    tick;
    ifm.data_valid = 1'b0;
    bits4 = 4'b1000;
    sipo  = '0;
    for (int i = 0; i < 4; i++) begin
      chk_bit_m("t1_bit", i, bits4[3-i]);
      chk("t1_ready", 32'(ifm.data_ready), 32'd1);
      sipo = {sipo[2:0], ifm.ser_out};
      tick;
    end
    chk("t1_sipo_q", 32'(sipo), 32'h8);
    chk_idle("t1_end");

    // Back-to-back A then 5 with valid held: 8 contiguous bits.
    s8             = 8'hA5;
    ifm.data_in    = 4'hA;
    ifm.data_valid = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) begin
      chk_bit_m("t2_bit", i, s8[7-i]);
      chk("t2_ready", 32'(ifm.data_ready), ((i >= 1) && (i <= 3)) ? 32'd0 : 32'd1);
      if (i == 0) ifm.data_in = 4'h5;
      if (i == 1) ifm.data_valid = 1'b0;
      tick;
    end
    chk_idle("t2_end");

    // C shifting, 9 held, 3 offered while the hold is full.
    s12            = 12'hC93;
    ifm.data_in    = 4'hC;
    ifm.data_valid = 1'b1;
    tick;
    for (int i = 0; i < 12; i++) begin
      chk_bit_m("t3_bit", i, s12[11-i]);
      chk("t3_ready", 32'(ifm.data_ready),
          (((i >= 1) && (i <= 3)) || ((i >= 5) && (i <= 7))) ? 32'd0 : 32'd1);
      if (i == 0) ifm.data_in = 4'h9;
      if (i == 1) ifm.data_in = 4'h3;
      if (i == 5) ifm.data_valid = 1'b0;
      tick;
    end
    chk_idle("t3_end");

    // Bit order: 0001 into both instances.
    bits4          = 4'b0001;   // MSB-first sequence 0,0,0,1
    lbits4         = 4'b1000;   // LSB-first sequence 1,0,0,0
    ifm.data_in    = 4'b0001;
    ifl.data_in    = 4'b0001;
    ifm.data_valid = 1'b1;
    ifl.data_valid = 1'b1;
    tick;
    ifm.data_valid = 1'b0;
    ifl.data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit_m("t4_msb", i, bits4[3-i]);
      chk("t4_lsb_valid", 32'(ifl.ser_valid), 32'd1);
      chk("t4_lsb_out",   32'(ifl.ser_out),   32'(lbits4[3-i]));
      chk("t4_lsb_first", 32'(ifl.ser_first), 32'(i == 0));
      chk("t4_lsb_last",  32'(ifl.ser_last),  32'(i == 3));
      tick;
    end
    chk_idle("t4_end");

    // Reset during bit 2 of F with 6 held.
    ifm.data_in    = 4'hF;
    ifm.data_valid = 1'b1;
    tick;
    ifm.data_in    = 4'h6;
    tick;
    ifm.data_valid = 1'b0;
    chk("t5_pre_out",   32'(ifm.ser_out),    32'd1);
    chk("t5_pre_valid", 32'(ifm.ser_valid),  32'd1);
    chk("t5_pre_ready", 32'(ifm.data_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_idle("t5_async");
    #1 rst_n = 1'b1;
    tick;
    chk_idle("t5_post1");
    tick;
    chk_idle("t5_post2");

    // Clean frame after the reset.
    bits4          = 4'h9;
    ifm.data_in    = 4'h9;
    ifm.data_valid = 1'b1;
    tick;
    ifm.data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit_m("t5_frame", i, bits4[3-i]);
      tick;
    end
    chk_idle("t5_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
